// File: rtl/pkt_dispatch_sched.sv
// Packet dispatch scheduler: round-robin credit grant, channel stamping, tag push.
// Define PKT_DISPATCH_ERRCNT_EN to count dropped orphan beats on err_count_o.
module pkt_dispatch_sched #(
  parameter int NCOUNT  = 4,
  parameter int CREDITS = 1,
  parameter int TAGW    = 8
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [63:0]       in_data_i,
  input  logic              in_valid_i,
  input  logic              in_sop_i,
  input  logic              in_eop_i,
  output logic              in_ready_o,
  output logic [63:0]       out_data_o,
  output logic              out_valid_o,
  output logic              out_sop_o,
  output logic              out_eop_o,
  output logic [5:0]        out_channel_o,
  input  logic              out_ready_i,
  output logic [TAGW-1:0]   tag_data_o,
  output logic              tag_valid_o,
  input  logic              tag_ready_i,
  input  logic [NCOUNT-1:0] done_i,
  output logic [15:0]       err_count_o
);

  localparam int PW = (NCOUNT > 1) ? $clog2(NCOUNT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    STREAM
  } state_e;

  state_e          state_q;
  logic [2:0]      cred_q [NCOUNT];
  logic [2:0]      cred_d [NCOUNT];
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   gidx;
  logic            gfound;
  logic            grant;
  logic [5:0]      chan_q;
  logic            live_q;
  logic            idle;
  logic            stream;
  logic            drop;

  assign idle   = (state_q == IDLE);
  assign stream = (state_q == STREAM);
  // live_q keeps in_ready low while reset is held or just released
  assign drop   = idle & live_q & in_valid_i & ~in_sop_i;

  always_comb begin
    int c;
    logic [PW-1:0] ci;
    c      = 0;
    ci     = '0;
    gfound = 1'b0;
    gidx   = '0;
    for (int k = 1; k <= NCOUNT; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NCOUNT) c = c - NCOUNT;
      ci = PW'(c);
      if (!gfound && cred_q[ci] != 3'd0) begin
        gfound = 1'b1;
        gidx   = ci;
      end
    end
  end

  assign grant = (state_q == PICK) & gfound & tag_ready_i;

  always_comb begin
    logic g;
    g = 1'b0;
    for (int i = 0; i < NCOUNT; i++) begin
      cred_d[i] = cred_q[i];
      g = grant && (gidx == PW'(i));
      if (g && !done_i[i])
        cred_d[i] = cred_q[i] - 3'd1;
      else if (!g && done_i[i] && cred_q[i] < 3'(CREDITS))
        cred_d[i] = cred_q[i] + 3'd1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NCOUNT - 1);
      chan_q  <= '0;
      live_q  <= 1'b0;
      for (int i = 0; i < NCOUNT; i++)
        cred_q[i] <= 3'(CREDITS);
    end else begin
      live_q <= 1'b1;
      for (int i = 0; i < NCOUNT; i++)
        cred_q[i] <= cred_d[i];
      unique case (state_q)
        IDLE: begin
          if (in_valid_i && in_sop_i)
            state_q <= PICK;
        end
        PICK: begin
          if (grant) begin
            ptr_q   <= gidx;
            chan_q  <= 6'(gidx);
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (in_valid_i && out_ready_i && in_eop_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o    = stream ? out_ready_i : drop;
  assign out_data_o    = in_data_i;
  assign out_valid_o   = stream & in_valid_i;
  assign out_sop_o     = stream & in_valid_i & in_sop_i;
  assign out_eop_o     = stream & in_valid_i & in_eop_i;
  assign out_channel_o = chan_q;
  assign tag_valid_o   = grant;
  assign tag_data_o    = grant ? TAGW'(gidx) : '0;

`ifdef PKT_DISPATCH_ERRCNT_EN
  logic [15:0] err_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)
      err_q <= '0;
    else if (drop && err_q != 16'hFFFF)
      err_q <= err_q + 16'd1;
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_pkt_dispatch_sched.sv
// Directed bench for pkt_dispatch_sched (NCOUNT=4, CREDITS=1).
// Expected channels, tags and latencies are hand-derived per test.
module tb_pkt_dispatch_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic [63:0] out_data;
  logic        out_valid, out_sop, out_eop, out_ready;
  logic [5:0]  out_channel;
  logic [7:0]  tag_data;
  logic        tag_valid, tag_ready;
  logic [3:0]  done;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pkt_dispatch_sched #(.NCOUNT(4), .CREDITS(1), .TAGW(8)) dut (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .in_data_i    (in_data),
    .in_valid_i   (in_valid),
    .in_sop_i     (in_sop),
    .in_eop_i     (in_eop),
    .in_ready_o   (in_ready),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_sop_o    (out_sop),
    .out_eop_o    (out_eop),
    .out_channel_o(out_channel),
    .out_ready_i  (out_ready),
    .tag_data_o   (tag_data),
    .tag_valid_o  (tag_valid),
    .tag_ready_i  (tag_ready),
    .done_i       (done),
    .err_count_o  (err_count)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One packet; done_vec pulsed at cycle done_cyc, tag_ready low on
  // cycles [tr_lo, tr_hi]; first output beat expected at cycle lat.
  task automatic run_pkt(input int n, input logic [63:0] base,
                         input int ch, input int lat, input bit tog,
                         input int done_cyc, input logic [3:0] done_vec,
                         input int tr_lo, input int tr_hi);
    int b = 0;
    int cyc = 0;
    int tags = 0;
    while (b < n && cyc < 200) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sop    = (b == 0);
      in_eop    = (b == n - 1);
      in_data   = base + 64'(b);
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      done      = (cyc == done_cyc) ? done_vec : 4'd0;
      tag_ready = !(cyc >= tr_lo && cyc <= tr_hi);
      #1;
      chk("tag_valid", 64'(tag_valid), 64'(cyc == lat - 1));
      if (tag_valid) begin
        tags++;
        chk("tag_data", 64'(tag_data), 64'(ch));
      end
      if (cyc < lat) begin
        chk("pre_in_ready", 64'(in_ready), 64'd0);
        chk("pre_out_valid", 64'(out_valid), 64'd0);
      end
      if (out_valid && out_ready) begin
        if (b == 0) chk("latency", 64'(cyc), 64'(lat));
        chk("data", out_data, base + 64'(b));
        chk("channel", 64'(out_channel), 64'(ch));
        chk("sop", 64'(out_sop), 64'(b == 0));
        chk("eop", 64'(out_eop), 64'(b == n - 1));
        b++;
      end
      cyc++;
    end
    chk("beats", 64'(b), 64'(n));
    chk("tags", 64'(tags), 64'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    done      = 4'd0;
    tag_ready = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] exp_err;
    rst_n = 1'b0; in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0;
    out_ready = 1; tag_ready = 1; done = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_tag_valid", 64'(tag_valid), 64'd0);
    chk("rst_channel", 64'(out_channel), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int p = 0; p < 4; p++)
      run_pkt(3, 64'h1000 * 64'(p + 1), p, 2, 0, -1, 4'd0, -1, -1);

    // no credit: held in PICK until done[2]
    run_pkt(2, 64'hA500, 2, 5, 0, 3, 4'b0100, -1, -1);
    // 8 beats with out_ready toggling
    run_pkt(8, 64'hBEEF_0000, 0, 2, 1, 0, 4'b0001, -1, -1);
    // tag_ready low 5 cycles in PICK
    run_pkt(3, 64'hC000, 1, 7, 0, 0, 4'b0010, 1, 5);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; in_sop = 0; in_eop = 0; in_data = 64'(i);
      #1;
      chk("orphan_ready", 64'(in_ready), 64'd1);
      chk("orphan_ovalid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    in_valid = 0;
    #1;
`ifdef PKT_DISPATCH_ERRCNT_EN
    exp_err = 16'd3;
`else
    exp_err = 16'd0;
`endif
    chk("err_count", 64'(err_count), 64'(exp_err));

    // partial packet on channel 3, then reset in STREAM
    @(negedge clk);
    done = 4'b1000; in_valid = 1; in_sop = 1; in_eop = 0; in_data = 64'h77;
    @(negedge clk);
    done = 4'd0;
    @(negedge clk);
    #1;
    chk("part_valid", 64'(out_valid), 64'd1);
    chk("part_channel", 64'(out_channel), 64'd3);
    @(negedge clk);
    in_sop = 0; in_data = 64'h78;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_sop", 64'(out_sop), 64'd0);
    chk("arst_out_eop", 64'(out_eop), 64'd0);
    chk("arst_channel", 64'(out_channel), 64'd0);
    chk("arst_tag_valid", 64'(tag_valid), 64'd0);
    chk("arst_tag_data", 64'(tag_data), 64'd0);
    chk("arst_err", 64'(err_count), 64'd0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1'b1;

    // credits restored: single-beat packets go to 0 then 1
    run_pkt(1, 64'hD0, 0, 2, 0, -1, 4'd0, -1, -1);
    run_pkt(1, 64'hD1, 1, 2, 0, -1, 4'd0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
